// File: rtl/fetch_ctrl.sv
// PC / instruction-register stage of the RISC core; tracks the program FSM state,
// issues instruction fetches, latches the IR and advances or redirects the PC at writeback.
package fetch_ctrl_pkg;
  typedef enum logic [2:0] {
    RESET_STATE = 3'd0,
    FETCH_INSTR = 3'd1,
    READ_OPS    = 3'd2,
    EXECUTE     = 3'd3,
    WRITEBACK   = 3'd4
  } state_type;
endpackage

module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned INSTR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  state_type          current_state,
  output logic               imem_rd,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt_req,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus1,
  output logic               halted,
  output logic [CNT_W-1:0]   retired_cnt
);

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    wrap_inc = a + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

  // The counter is a debug aid; a wrapped count would be misleading, so it sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) sat_inc = c;
    else    sat_inc = c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              fetch_en;
  logic              wb_en;
  logic [ADDR_W-1:0] pc_next;

  always_comb begin
    fetch_en = (current_state == FETCH_INSTR) && !halted;
    wb_en    = (current_state == WRITEBACK) && !halted;
    pc_next  = branch_taken ? branch_target : wrap_inc(pc);
  end

  assign imem_rd   = fetch_en;
  assign imem_addr = pc;
  assign pc_plus1  = wrap_inc(pc);

  // Fetch stage: IR capture (memory read is combinational, so data is ready in the same cycle).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr <= '0;
    end else if (fetch_en) begin
      instr <= imem_data;
    end
  end

  // Writeback stage: PC redirect/advance, retire count, halt capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_VEC;
      retired_cnt <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (fetch_en) begin
      instr_valid <= 1'b1;
    end else if (wb_en) begin
      pc          <= pc_next;
      retired_cnt <= sat_inc(retired_cnt);
      instr_valid <= 1'b0;
      halted      <= halt_req;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: drives the FSM state sequence by hand and checks
// fetch, IR, PC/branch, wrap, halt, async reset and counter saturation.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  state_type   current_state;
  logic        imem_rd;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        halt_req;
  logic [15:0] instr;
  logic        instr_valid;
  logic [7:0]  pc;
  logic [7:0]  pc_plus1;
  logic        halted;
  logic [15:0] retired_cnt;

  logic        s_imem_rd;
  logic [7:0]  s_imem_addr;
  logic [15:0] s_instr;
  logic        s_instr_valid;
  logic [7:0]  s_pc;
  logic [7:0]  s_pc_plus1;
  logic        s_halted;
  logic [1:0]  s_retired_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  fetch_ctrl u_dut (
    .clk(clk), .reset(reset), .current_state(current_state),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt_req(halt_req),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus1(pc_plus1),
    .halted(halted), .retired_cnt(retired_cnt)
  );

  // Narrow counter instance so saturation is reachable in a handful of instructions.
  fetch_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .current_state(current_state),
    .imem_rd(s_imem_rd), .imem_addr(s_imem_addr), .imem_data(imem_data),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt_req(halt_req),
    .instr(s_instr), .instr_valid(s_instr_valid), .pc(s_pc), .pc_plus1(s_pc_plus1),
    .halted(s_halted), .retired_cnt(s_retired_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full FSM round; ends parked in RESET_STATE (which holds all registers).
  task automatic do_instr(input logic [15:0] d, input logic [7:0] exp_addr,
                          input logic br, input logic [7:0] tgt, input logic hr);
    @(negedge clk); current_state = FETCH_INSTR; imem_data = d; #1;
    chk("fetch_rd", 32'(imem_rd), 32'd1);
    chk("fetch_addr", 32'(imem_addr), 32'(exp_addr));
    @(negedge clk); current_state = READ_OPS; imem_data = 16'hDEAD; #1;
    chk("ir_readops", 32'(instr), 32'(d));
    chk("ir_valid", 32'(instr_valid), 32'd1);
    chk("rd_readops", 32'(imem_rd), 32'd0);
    @(negedge clk); current_state = EXECUTE;
    @(negedge clk); current_state = WRITEBACK;
    branch_taken = br; branch_target = tgt; halt_req = hr; #1;
    chk("ir_wb", 32'(instr), 32'(d));
    @(negedge clk); current_state = RESET_STATE;
    branch_taken = 1'b0; branch_target = 8'h00; halt_req = 1'b0; #1;
    exp_cnt++;
    chk("cnt", 32'(retired_cnt), 32'(exp_cnt));
    chk("sat_cnt", 32'(s_retired_cnt), (exp_cnt > 3) ? 32'd3 : 32'(exp_cnt));
    chk("valid_clr", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; current_state = RESET_STATE; imem_data = 16'h0;
    branch_taken = 1'b0; branch_target = 8'h00; halt_req = 1'b0;
    #12;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_cnt", 32'(retired_cnt), 32'd0);
    chk("rst_rd", 32'(imem_rd), 32'd0);
    @(negedge clk); reset = 1'b0;

    do_instr(16'h1111, 8'h00, 1'b0, 8'h00, 1'b0);
    do_instr(16'h2222, 8'h01, 1'b0, 8'h00, 1'b0);
    do_instr(16'h3333, 8'h02, 1'b0, 8'h00, 1'b0);
    chk("pc_after3", 32'(pc), 32'h3);
    chk("cnt_after3", 32'(retired_cnt), 32'd3);

    // Undefined encoding: no read, nothing moves.
    @(negedge clk); current_state = state_type'(3'd7); #1;
    chk("undef_rd", 32'(imem_rd), 32'd0);
    @(negedge clk); current_state = RESET_STATE; #1;
    chk("undef_pc", 32'(pc), 32'h3);
    chk("undef_cnt", 32'(retired_cnt), 32'd3);

    // Branch from pc 5 to 0x40.
    do_instr(16'h0004, 8'h03, 1'b0, 8'h00, 1'b0);
    do_instr(16'h0005, 8'h04, 1'b0, 8'h00, 1'b0);
    do_instr(16'h0006, 8'h05, 1'b1, 8'h40, 1'b0);
    chk("br_pc", 32'(pc), 32'h40);
    chk("br_plus1", 32'(pc_plus1), 32'h41);
    do_instr(16'h0007, 8'h40, 1'b1, 8'hFF, 1'b0);

    // Wrap 0xFF -> 0x00.
    chk("pc_ff", 32'(pc), 32'hFF);
    chk("plus1_ff", 32'(pc_plus1), 32'h00);
    do_instr(16'h0008, 8'hFF, 1'b0, 8'h00, 1'b0);
    chk("wrap_pc", 32'(pc), 32'h00);
    chk("wrap_plus1", 32'(pc_plus1), 32'h01);

    // Halt together with branch to 0x20.
    do_instr(16'h0009, 8'h00, 1'b1, 8'h20, 1'b1);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", 32'(pc), 32'h20);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      case (i % 4)
        0: current_state = FETCH_INSTR;
        1: current_state = READ_OPS;
        2: current_state = EXECUTE;
        default: current_state = WRITEBACK;
      endcase
      imem_data = 16'hBEEF; branch_taken = 1'b1; branch_target = 8'h55; #1;
      chk("halt_rd", 32'(imem_rd), 32'd0);
    end
    @(negedge clk); current_state = RESET_STATE; branch_taken = 1'b0; #1;
    chk("halt_pc_hold", 32'(pc), 32'h20);
    chk("halt_cnt_hold", 32'(retired_cnt), 32'(exp_cnt));
    chk("halt_ir_hold", 32'(instr), 32'h0009);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    chk("halt_still", 32'(halted), 32'd1);

    // Clear halt, reach pc 7 with IR 0xABCD, reset asynchronously in EXECUTE.
    @(negedge clk); reset = 1'b1; #1;
    chk("reset2_halted", 32'(halted), 32'd0);
    @(negedge clk); reset = 1'b0; exp_cnt = 0;
    do_instr(16'h0001, 8'h00, 1'b1, 8'h07, 1'b0);
    @(negedge clk); current_state = FETCH_INSTR; imem_data = 16'hABCD;
    @(negedge clk); current_state = READ_OPS;
    @(negedge clk); current_state = EXECUTE; #1;
    chk("pre_rst_ir", 32'(instr), 32'hABCD);
    chk("pre_rst_pc", 32'(pc), 32'h07);
    #1 reset = 1'b1; #1;
    chk("async_pc", 32'(pc), 32'h0);
    chk("async_ir", 32'(instr), 32'h0);
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_halted", 32'(halted), 32'd0);
    chk("async_cnt", 32'(retired_cnt), 32'd0);
    @(negedge clk); reset = 1'b0; current_state = RESET_STATE; exp_cnt = 0;

    // Saturation on the narrow instance: 0,1,2,3 then stays at 3.
    for (int i = 0; i < 5; i++)
      do_instr(16'h5000 + 16'(i), 8'(i), 1'b0, 8'h00, 1'b0);
    chk("sat_hold", 32'(s_retired_cnt), 32'd3);
    chk("wide_cnt", 32'(retired_cnt), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Program-counter and instruction-register stage of the RISC core, directly downstream of the program FSM.
- Consumes the FSM's current_state and, in step with it:
  - issues instruction-memory reads;
  - latches the fetched instruction into the IR;
  - advances or redirects the PC at writeback.
- Also provides a halt mechanism and a retired-instruction counter for debug.

Parameters:
- ADDR_W, 8: PC / instruction-memory address width.
- INSTR_W, 16: instruction width.
- RESET_VEC, 0: PC value after reset.
- CNT_W, 16: retired-instruction counter width.

Ports:
- clk  input  1  cpu clock.
- reset  input  1  cpu reset; asynchronous, active-high.
- current_state  input  `state_type  FSM state; uses the shared risc.h encoding (RESET_STATE, FETCH_INSTR, READ_OPS, EXECUTE, WRITEBACK).
- imem_rd  output  1  instruction-memory read strobe.
- imem_addr  output  ADDR_W  instruction-memory address.
- imem_data  input  INSTR_W  instruction-memory read data; asynchronous read, valid in the same cycle as imem_addr.
- branch_taken  input  1  execute unit requests redirect; sampled only in WRITEBACK.
- branch_target  input  ADDR_W  redirect address; sampled only in WRITEBACK.
- halt_req  input  1  stop after the current instruction; sampled only in WRITEBACK.
- instr  output  INSTR_W  instruction register.
- instr_valid  output  1  instr holds the in-flight instruction.
- pc  output  ADDR_W  address of the in-flight / next instruction.
- pc_plus1  output  ADDR_W  (pc + 1) mod 2^ADDR_W, combinational; used as the link address.
- halted  output  1  core halted.
- retired_cnt  output  CNT_W  instructions completed.

Behaviour:
- Reset (async, any time, including mid-instruction) sets:
  - pc = RESET_VEC, instr = 0, instr_valid = 0, halted = 0, retired_cnt = 0;
  - imem_rd = 0 as a combinational consequence.
- Combinational fetch outputs:
  - imem_rd = (current_state == FETCH_INSTR) && !halted;
  - imem_addr = pc at all times.
- Registered actions occur at the posedge on which current_state holds the named value:
  - FETCH_INSTR, !halted: instr <= imem_data; instr_valid <= 1. The IR is therefore stable from the READ_OPS cycle through WRITEBACK, giving 1 cycle of fetch latency.
  - READ_OPS, EXECUTE: all registers hold.
  - WRITEBACK, !halted, in priority order:
    - pc <= branch_taken ? branch_target : pc + 1, wrapping mod 2^ADDR_W (0xFF -> 0x00 at ADDR_W = 8);
    - retired_cnt <= retired_cnt + 1, saturating at all-ones;
    - instr_valid <= 0;
    - halted <= halt_req.
  - halt_req together with branch_taken: PC still takes branch_target, then halted = 1. The resume point is therefore defined.
  - RESET_STATE or any undefined encoding: all registers hold; imem_rd = 0.
- Halted behaviour:
  - no reads;
  - pc, instr and retired_cnt frozen; instr_valid stays 0;
  - the FSM keeps cycling, which is harmless;
  - only reset clears halted.
- FSM in WRITEBACK while instr_valid = 0 (e.g. reset released mid-sequence is not possible, but treat it as defensive): the PC update and counter increment still occur as specified. No error output.
- Width rules:
  - branch_target is used unmodified;
  - pc_plus1 is truncated to ADDR_W;
  - retired_cnt never wraps.

Test Plan:
- Reset, then 3 full FSM rounds with imem returning 0x1111, 0x2222, 0x3333 -> imem_addr 0, 1, 2 on the FETCH cycles; instr shows each value from READ_OPS; pc = 3 and retired_cnt = 3 afterwards.
- branch_taken = 1, branch_target = 0x40 during WRITEBACK of instr at pc 5 -> next FETCH imem_addr = 0x40; pc_plus1 = 0x41.
- pc = 0xFF with no branch -> after WRITEBACK pc = 0x00; retired_cnt increments.
- halt_req = 1 and branch to 0x20 in the same WRITEBACK -> halted = 1, pc = 0x20, imem_rd stays 0 for 20 further FSM cycles, retired_cnt frozen.
- Reset asserted asynchronously mid-EXECUTE with instr = 0xABCD, pc = 7 -> immediately pc = RESET_VEC, instr = 0, instr_valid = 0, halted = 0.
- Force retired_cnt to 0xFFFE (CNT_W = 16), run 3 instructions -> count reaches 0xFFFF and holds.
